// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared ALU, mux-select and opcode constants for the MIPS datapath and controller
package mips_pkg;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRL = 5'b00101;
  localparam logic [4:0] ALU_SRA = 5'b00110;
  localparam logic [4:0] ALU_LUI = 5'b00111;
  localparam logic [4:0] ALU_ORI = 5'b01000;
  localparam logic [4:0] ALU_SUB = 5'b01001;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REG   = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_HOLD   = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_OR   = 6'h25;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// rtl/mips_regfile.sv - register file: two combinational read ports, one synchronous write port, r0 reads zero
module mips_regfile
  import mips_pkg::*;
#(
  parameter int REG_COUNT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  i_raddr_a,
  output logic [31:0] o_rdata_a,
  input  logic [4:0]  i_raddr_b,
  output logic [31:0] o_rdata_b,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);

  logic [31:0] r_regs [REG_COUNT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // No write-through bypass: a same-cycle read sees the pre-write contents.
  assign o_rdata_a = (i_raddr_a == 5'd0) ? 32'd0 : r_regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == 5'd0) ? 32'd0 : r_regs[i_raddr_b];

endmodule

// File: rtl/mips_datapath.sv
// rtl/mips_datapath.sv - multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut, register file and ALU
module mips_datapath
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          REG_COUNT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        PCWriteCond,
  input  logic [1:0]  PCSource,
  input  logic        IorD,
  input  logic        MemToReg,
  input  logic        IRWrite,
  input  logic        RegWrite,
  input  logic        RegDst,
  input  logic [1:0]  ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [4:0]  ALUOP,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [5:0]  op,
  output logic [5:0]  funct
);

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_mdr;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_aluout;

  logic [31:0] w_rs_data;
  logic [31:0] w_rt_data;
  logic [4:0]  w_waddr;
  logic [31:0] w_wdata;
  logic [31:0] w_imm_sext;
  logic [31:0] w_src_a;
  logic [31:0] w_src_b;
  logic [31:0] w_alu_result;
  logic        w_zero;
  logic [31:0] w_pc_next;
  logic        w_pc_en;

  assign w_waddr    = RegDst ? r_ir[15:11] : r_ir[20:16];
  assign w_wdata    = MemToReg ? r_mdr : r_aluout;
  assign w_imm_sext = sign_ext16(r_ir[15:0]);

  mips_regfile #(
    .REG_COUNT (REG_COUNT)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .i_raddr_a (r_ir[25:21]),
    .o_rdata_a (w_rs_data),
    .i_raddr_b (r_ir[20:16]),
    .o_rdata_b (w_rt_data),
    .i_we      (RegWrite),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata)
  );

  always_comb begin
    w_src_a = '0;
    case (ALUSrcA)
      SRCA_PC:    w_src_a = r_pc;
      SRCA_REG:   w_src_a = r_a;
      SRCA_SHAMT: w_src_a = {27'd0, r_ir[10:6]};
      default:    w_src_a = '0;
    endcase
  end

  always_comb begin
    w_src_b = '0;
    case (ALUSrcB)
      SRCB_REG:  w_src_b = r_b;
      SRCB_FOUR: w_src_b = 32'd4;
      SRCB_IMM:  w_src_b = w_imm_sext;
      default:   w_src_b = {w_imm_sext[29:0], 2'b00};
    endcase
  end

  // Shifts take their amount from operand A so the shamt field and rs share one path.
  always_comb begin
    w_alu_result = '0;
    case (ALUOP)
      ALU_ADD: w_alu_result = w_src_a + w_src_b;
      ALU_OR:  w_alu_result = w_src_a | w_src_b;
      ALU_SLL: w_alu_result = w_src_b << w_src_a[4:0];
      ALU_SRL: w_alu_result = w_src_b >> w_src_a[4:0];
      ALU_SRA: w_alu_result = $unsigned($signed(w_src_b) >>> w_src_a[4:0]);
      ALU_LUI: w_alu_result = {w_src_b[15:0], 16'd0};
      ALU_ORI: w_alu_result = w_src_a | {16'd0, w_src_b[15:0]};
      ALU_SUB: w_alu_result = w_src_a - w_src_b;
      default: w_alu_result = '0;
    endcase
  end

  assign w_zero = (w_alu_result == 32'd0);

  always_comb begin
    w_pc_next = r_pc;
    case (PCSource)
      PCSRC_ALU:    w_pc_next = w_alu_result;
      PCSRC_ALUOUT: w_pc_next = r_aluout;
      PCSRC_JUMP:   w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
      default:      w_pc_next = r_pc;
    endcase
  end

  assign w_pc_en = PCWrite | (PCWriteCond & w_zero);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_mdr    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
    end else begin
      if (w_pc_en) begin
        r_pc <= w_pc_next;
      end
      if (IRWrite) begin
        r_ir <= mem_rdata;
      end
      r_mdr    <= mem_rdata;
      r_a      <= w_rs_data;
      r_b      <= w_rt_data;
      r_aluout <= w_alu_result;
    end
  end

  assign mem_addr  = IorD ? r_aluout : r_pc;
  assign mem_wdata = r_b;
  assign op        = r_ir[31:26];
  assign funct     = r_ir[5:0];

endmodule

// File: tb/tb_mips_datapath.sv
// tb/tb_mips_datapath.sv - self-checking bench: directed instruction sequences plus random control cycles vs a reference model
module tb_mips_datapath;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic        PCWrite;
  logic        PCWriteCond;
  logic [1:0]  PCSource;
  logic        IorD;
  logic        MemToReg;
  logic        IRWrite;
  logic        RegWrite;
  logic        RegDst;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [4:0]  ALUOP;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [5:0]  op;
  logic [5:0]  funct;

  mips_datapath #(
    .RESET_PC  (RST_PC),
    .REG_COUNT (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .PCSource    (PCSource),
    .IorD        (IorD),
    .MemToReg    (MemToReg),
    .IRWrite     (IRWrite),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOP       (ALUOP),
    .mem_rdata   (mem_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .op          (op),
    .funct       (funct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Architectural model of the datapath's visible state.
  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;
  logic [31:0] m_regs [32];
  bit          m_valid = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] code, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] scale;
    logic [31:0] r;
    scale = 32'd1 << x[4:0];
    case (code)
      5'd0:    r = x + y;
      5'd1:    r = x | y;
      5'd4:    r = y * scale;
      5'd5:    r = y / scale;
      5'd6:    r = y[31] ? ~((~y) / scale) : y / scale;
      5'd7:    r = y * 32'h0001_0000;
      5'd8:    r = x | (y % 32'h0001_0000);
      5'd9:    r = x - y;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic model_clock();
    logic [31:0] x, y, imm, res, n_a, n_b;
    logic [4:0]  dst;
    if (reset) begin
      m_pc = RST_PC;
      m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_aluout = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
      m_valid = 1;
      return;
    end
    imm = {{16{m_ir[15]}}, m_ir[15:0]};
    x = (ALUSrcA == 2'd0) ? m_pc : (ALUSrcA == 2'd1) ? m_a :
        (ALUSrcA == 2'd2) ? 32'(m_ir[10:6]) : 32'd0;
    y = (ALUSrcB == 2'd0) ? m_b : (ALUSrcB == 2'd1) ? 32'd4 :
        (ALUSrcB == 2'd2) ? imm : imm * 4;
    res = ref_alu(ALUOP, x, y);
    n_a = m_regs[m_ir[25:21]];
    n_b = m_regs[m_ir[20:16]];
    if (RegWrite) begin
      dst = RegDst ? m_ir[15:11] : m_ir[20:16];
      if (dst != 0) m_regs[dst] = MemToReg ? m_mdr : m_aluout;
    end
    if (PCWrite || (PCWriteCond && res == 0)) begin
      case (PCSource)
        2'd0: m_pc = res;
        2'd1: m_pc = m_aluout;
        2'd2: m_pc = {m_pc[31:28], m_ir[25:0], 2'b00};
        default: m_pc = m_pc;
      endcase
    end
    if (IRWrite) m_ir = mem_rdata;
    m_mdr = mem_rdata;
    m_a = n_a;
    m_b = n_b;
    m_aluout = res;
  endtask

  task automatic step();
    #1;
    if (m_valid) chk("addr_pre", mem_addr, IorD ? m_aluout : m_pc);
    @(posedge clk);
    #1;
    model_clock();
    chk("addr_post", mem_addr, IorD ? m_aluout : m_pc);
    chk("wdata", mem_wdata, m_b);
    chk("op", 32'(op), 32'(m_ir[31:26]));
    chk("funct", 32'(funct), 32'(m_ir[5:0]));
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 0; PCWrite = 0; PCWriteCond = 0; PCSource = 2'b11; IorD = 0;
    MemToReg = 0; IRWrite = 0; RegWrite = 0; RegDst = 0;
    ALUSrcA = 0; ALUSrcB = 0; ALUOP = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    idle(); reset = 1; step(); idle();
  endtask

  task automatic fetch(input logic [31:0] instr);
    idle(); IRWrite = 1; ALUSrcB = 2'b01; PCWrite = 1; PCSource = 2'b00; mem_rdata = instr;
    step();
  endtask

  task automatic decode();
    idle(); step();
  endtask

  task automatic exec(input logic [1:0] sa, input logic [1:0] sb, input logic [4:0] aop);
    idle(); ALUSrcA = sa; ALUSrcB = sb; ALUOP = aop; step();
  endtask

  task automatic wb(input logic dst, input logic m2r);
    idle(); RegWrite = 1; RegDst = dst; MemToReg = m2r; step();
  endtask

  task automatic jump_decode();
    idle(); PCWrite = 1; PCSource = 2'b10; step();
  endtask

  task automatic look_pc(input string tag, input logic [31:0] exp);
    idle(); IorD = 0; #1; chk(tag, mem_addr, exp);
  endtask

  task automatic look_aluout(input string tag, input logic [31:0] exp);
    idle(); IorD = 1; #1; chk(tag, mem_addr, exp);
  endtask

  task automatic load_imm(input logic [4:0] rt, input logic [15:0] imm);
    fetch({6'h0d, 5'd0, rt, imm}); decode(); exec(2'b01, 2'b10, 5'd8); wb(0, 0);
  endtask

  task automatic lw_seq(input logic rst_at_wb);
    fetch(32'h8C0C_0200); decode(); exec(2'b01, 2'b10, 5'd0);
    idle(); IorD = 1; mem_rdata = 32'hFFFF_FF80; #1;
    chk("lw_addr", mem_addr, 32'h0000_0200);
    step();
    idle(); RegWrite = 1; MemToReg = 1; RegDst = 0; reset = rst_at_wb; step();
  endtask

  logic [4:0] alu_codes [8] = '{5'd0, 5'd1, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9};

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    idle();
    @(negedge clk);

    do_reset();
    look_pc("reset_pc", RST_PC);
    chk("reset_b", mem_wdata, 32'd0);
    chk("reset_op", 32'(op), 32'd0);

    fetch(32'h3408_1234);
    chk("fetch_op", 32'(op), 32'h0000_000d);
    chk("fetch_funct", 32'(funct), 32'h0000_0034);
    look_pc("fetch_pc", 32'h0000_0104);
    decode();
    exec(2'b01, 2'b10, 5'd8);
    look_aluout("ori_alu", 32'h0000_1234);
    wb(0, 0); decode();
    chk("ori_r8", mem_wdata, 32'h0000_1234);

    fetch(32'h3408_FFFF); decode(); exec(2'b01, 2'b10, 5'd8); wb(0, 0); decode();
    chk("ori_ffff_r8", mem_wdata, 32'h0000_FFFF);

    fetch(32'h3C09_8000); decode(); exec(2'b11, 2'b10, 5'd7); wb(0, 0);
    fetch(32'h0009_5103); decode(); exec(2'b10, 2'b00, 5'd6);
    look_aluout("sra_alu", 32'hF800_0000);
    wb(1, 0);
    fetch(32'h000A_0000); decode();
    chk("sra_r10", mem_wdata, 32'hF800_0000);

    fetch(32'h0009_0103); decode(); exec(2'b10, 2'b00, 5'd6); wb(1, 0);
    fetch(32'h0000_0000); decode();
    chk("r0_zero", mem_wdata, 32'd0);

    load_imm(5'd8, 16'd5); load_imm(5'd9, 16'd5); load_imm(5'd11, 16'd6);
    fetch(32'h0800_0041); jump_decode();
    look_pc("jmp_104", 32'h0000_0104);
    fetch(32'h1109_FFFE);
    look_pc("beq_fetch_pc", 32'h0000_0108);
    exec(2'b00, 2'b11, 5'd0);
    look_aluout("beq_target", 32'h0000_0100);
    idle(); ALUSrcA = 2'b01; ALUSrcB = 2'b00; ALUOP = 5'd9; PCWriteCond = 1; PCSource = 2'b01; step();
    look_pc("beq_taken", 32'h0000_0100);

    fetch(32'h0800_0041); jump_decode();
    fetch(32'h110B_FFFE);
    exec(2'b00, 2'b11, 5'd0);
    idle(); ALUSrcA = 2'b01; ALUSrcB = 2'b00; ALUOP = 5'd9; PCWriteCond = 1; PCSource = 2'b01; step();
    look_pc("beq_not_taken", 32'h0000_0108);

    fetch(32'h3C00_1000);
    idle(); ALUSrcA = 2'b11; ALUSrcB = 2'b10; ALUOP = 5'd7; PCWrite = 1; PCSource = 2'b00; step();
    look_pc("lui_pc", 32'h1000_0000);
    fetch(32'h0800_0040);
    look_pc("j_fetch_pc", 32'h1000_0004);
    jump_decode();
    look_pc("jump_pc", 32'h1000_0100);

    lw_seq(1'b0);
    fetch(32'h000C_0000); decode();
    chk("lw_r12", mem_wdata, 32'hFFFF_FF80);

    do_reset();
    lw_seq(1'b1);
    look_pc("rst_wb_pc", RST_PC);
    fetch(32'h000C_0000); decode();
    chk("rst_wb_r12", mem_wdata, 32'd0);

    for (int n = 0; n < 500; n++) begin
      idle();
      reset       = ($urandom_range(0, 39) == 0);
      PCWrite     = ($urandom_range(0, 3) == 0);
      PCWriteCond = ($urandom_range(0, 3) == 0);
      PCSource    = 2'($urandom_range(0, 3));
      IorD        = 1'($urandom_range(0, 1));
      MemToReg    = 1'($urandom_range(0, 1));
      IRWrite     = ($urandom_range(0, 2) == 0);
      RegWrite    = 1'($urandom_range(0, 1));
      RegDst      = 1'($urandom_range(0, 1));
      ALUSrcA     = 2'($urandom_range(0, 3));
      ALUSrcB     = 2'($urandom_range(0, 3));
      ALUOP       = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : alu_codes[$urandom_range(0, 7)];
      mem_rdata   = $urandom;
      if ($urandom_range(0, 7) == 0) mem_rdata = mem_rdata & 32'hFFFF_0000;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
